// File: rtl/csa_accum_ctrl.sv
// Multi-operand unsigned accumulator: one 3:2 carry-save compression per accepted operand,
// a single carry-propagate add at the end, valid/ready handshakes on both sides.

module CsaCompress3to2 #(
    parameter int W = 24
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_c,
    output logic [W-1:0] o_sum,
    output logic [W-1:0] o_carry
);

    logic [W-1:0] w_majority;

    assign w_majority = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
    assign o_sum      = i_a ^ i_b ^ i_c;
    // The carry out of the top bit is dropped; the accumulator is sized so it is always zero.
    assign o_carry    = {w_majority[W-2:0], 1'b0};

endmodule

module csa_accum_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic [CNT_W-1:0]         i_len,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [WIDTH-1:0]         i_in_data,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [WIDTH+CNT_W-1:0]   o_out_sum,
    output logic                     o_busy
);

    localparam int ACC_W = WIDTH + CNT_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } stateT;

    stateT             r_state;
    logic [ACC_W-1:0]  r_sumVec;
    logic [ACC_W-1:0]  r_carryVec;
    logic [CNT_W-1:0]  r_cnt;
    logic [ACC_W-1:0]  r_outSum;
    logic              r_inReady;
    logic              r_outValid;
    logic              r_busy;

    logic [ACC_W-1:0]  w_xExt;
    logic [ACC_W-1:0]  w_csaSum;
    logic [ACC_W-1:0]  w_csaCarry;
    logic              w_accept;

    assign w_xExt   = {{CNT_W{1'b0}}, i_in_data};
    assign w_accept = i_in_valid & r_inReady;

    CsaCompress3to2 #(
        .W(ACC_W)
    ) u_csa (
        .i_a    (w_xExt),
        .i_b    (r_sumVec),
        .i_c    (r_carryVec),
        .o_sum  (w_csaSum),
        .o_carry(w_csaCarry)
    );

    // Handshake outputs are registered alongside the state so they never depend on
    // i_in_valid or i_out_ready combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_sumVec   <= '0;
            r_carryVec <= '0;
            r_cnt      <= '0;
            r_outSum   <= '0;
            r_inReady  <= 1'b0;
            r_outValid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_sumVec   <= '0;
                        r_carryVec <= '0;
                        r_cnt      <= i_len;
                        r_busy     <= 1'b1;
                        if (i_len != '0) begin
                            r_state   <= ACCUM;
                            r_inReady <= 1'b1;
                        end else begin
                            r_state   <= RESOLVE;
                        end
                    end
                end
                ACCUM: begin
                    if (w_accept) begin
                        r_sumVec   <= w_csaSum;
                        r_carryVec <= w_csaCarry;
                        r_cnt      <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state   <= RESOLVE;
                            r_inReady <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    r_outSum   <= r_sumVec + r_carryVec;
                    r_state    <= DONE;
                    r_outValid <= 1'b1;
                end
                DONE: begin
                    if (i_out_ready) begin
                        r_state    <= IDLE;
                        r_outValid <= 1'b0;
                        r_busy     <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_inReady  <= 1'b0;
                    r_outValid <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready  = r_inReady;
    assign o_out_valid = r_outValid;
    assign o_out_sum   = r_outSum;
    assign o_busy      = r_busy;

    // The operand and result sides are never open at the same time.
    assert property (@(posedge clk) disable iff (rst) !(r_inReady && r_outValid));
    assert property (@(posedge clk) disable iff (rst) (r_inReady || r_outValid) |-> r_busy);

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Directed bench for csa_accum_ctrl: the driver queues expected sums, a negedge monitor
// pops and compares them on every result handshake.

module tb_csa_accum_ctrl;

    localparam int WIDTH = 16;
    localparam int CNT_W = 8;
    localparam int ACC_W = WIDTH + CNT_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_start;
    logic [CNT_W-1:0]  i_len;
    logic              i_in_valid;
    logic              o_in_ready;
    logic [WIDTH-1:0]  i_in_data;
    logic              o_out_valid;
    logic              i_out_ready;
    logic [ACC_W-1:0]  o_out_sum;
    logic              o_busy;

    int compared   = 0;
    int mismatched = 0;

    logic [ACC_W-1:0]  expQ[$];
    logic [WIDTH-1:0]  opQ[$];
    int                gapQ[$];

    always #5 clk = ~clk;

    csa_accum_ctrl #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_len      (i_len),
        .i_in_valid (i_in_valid),
        .o_in_ready (o_in_ready),
        .i_in_data  (i_in_data),
        .o_out_valid(o_out_valid),
        .i_out_ready(i_out_ready),
        .o_out_sum  (o_out_sum),
        .o_busy     (o_busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearOps();
        opQ.delete();
        gapQ.delete();
    endtask

    // gap = idle in_valid cycles inserted before this operand is presented
    task automatic addOp(input logic [WIDTH-1:0] d, input int gap);
        opQ.push_back(d);
        gapQ.push_back(gap);
    endtask

    // Scoreboard monitor: one comparison per result handshake.
    always @(negedge clk) begin
        logic [ACC_W-1:0] expSum;
        if (!rst && o_out_valid && i_out_ready) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_result: got 0x%0h, expected no result", o_out_sum);
            end else begin
                expSum = expQ.pop_front();
                checkOutput("out_sum", 32'(o_out_sum), 32'(expSum));
            end
        end
    end

    task automatic applyStimulus(input int len, input logic [ACC_W-1:0] expSum,
                                 input int expLat, input int holdCycles);
        int lat;
        int k;
        int gapLeft;
        bit sawReady;
        bit accept;
        expQ.push_back(expSum);
        i_start     = 1'b1;
        i_len       = len[CNT_W-1:0];
        i_in_valid  = 1'b0;
        i_out_ready = (holdCycles == 0);
        step();
        i_start  = 1'b0;
        lat      = 1;
        k        = 0;
        sawReady = 1'b0;
        gapLeft  = (len > 0) ? gapQ[0] : 0;
        while (!o_out_valid && lat < len + 50) begin
            if (o_in_ready) sawReady = 1'b1;
            if (k < len && gapLeft == 0) begin
                i_in_valid = 1'b1;
                i_in_data  = opQ[k];
            end else begin
                i_in_valid = 1'b0;
                if (gapLeft > 0) gapLeft--;
            end
            accept = i_in_valid && o_in_ready;
            step();
            lat++;
            if (accept) begin
                k++;
                gapLeft = (k < len) ? gapQ[k] : 0;
            end
        end
        i_in_valid = 1'b0;
        if (!o_out_valid) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL result_timeout: got no out_valid after %0d cycles, expected 0x%0h", lat, expSum);
            return;
        end
        checkOutput("latency", 32'(lat), 32'(expLat));
        checkOutput("accepted_count", 32'(k), 32'(len));
        if (len == 0) checkOutput("in_ready_len0", 32'(sawReady), 32'd0);
        if (holdCycles > 0) begin
            for (int i = 0; i < holdCycles; i++) begin
                i_start = (i == 0);
                i_len   = 8'd9;
                step();
                checkOutput("hold_valid", 32'(o_out_valid), 32'd1);
                checkOutput("hold_sum", 32'(o_out_sum), 32'(expSum));
            end
            i_start     = 1'b0;
            i_out_ready = 1'b1;
        end
        step();
        checkOutput("idle_busy", 32'(o_busy), 32'd0);
        checkOutput("idle_valid", 32'(o_out_valid), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        i_start     = 1'b0;
        i_len       = '0;
        i_in_valid  = 1'b0;
        i_in_data   = '0;
        i_out_ready = 1'b0;
        #12;
        checkOutput("reset_in_ready", 32'(o_in_ready), 32'd0);
        checkOutput("reset_out_valid", 32'(o_out_valid), 32'd0);
        checkOutput("reset_busy", 32'(o_busy), 32'd0);
        checkOutput("reset_out_sum", 32'(o_out_sum), 32'd0);
        step();
        rst = 1'b0;
        step();

        $display("[TB] len=4, operands 1..4");
        clearOps();
        addOp(16'h0001, 0); addOp(16'h0002, 0); addOp(16'h0003, 0); addOp(16'h0004, 0);
        applyStimulus(4, 24'd10, 6, 0);

        $display("[TB] reset after 3 of 5 operands");
        i_start    = 1'b1;
        i_len      = 8'd5;
        i_in_valid = 1'b1;
        i_in_data  = 16'h0007;
        step();
        i_start = 1'b0;
        repeat (3) step();
        checkOutput("pre_reset_busy", 32'(o_busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_in_ready", 32'(o_in_ready), 32'd0);
        checkOutput("abort_out_valid", 32'(o_out_valid), 32'd0);
        checkOutput("abort_busy", 32'(o_busy), 32'd0);
        checkOutput("abort_out_sum", 32'(o_out_sum), 32'd0);
        i_in_valid = 1'b0;
        step();
        rst = 1'b0;
        step();

        $display("[TB] len=2 after abort");
        clearOps();
        addOp(16'h0001, 0); addOp(16'h0002, 0);
        applyStimulus(2, 24'd3, 4, 0);

        $display("[TB] len=255, all 0xFFFF");
        clearOps();
        for (int i = 0; i < 255; i++) addOp(16'hFFFF, 0);
        applyStimulus(255, 24'hFEFF01, 257, 0);

        $display("[TB] len=3 with a 2-cycle in_valid gap");
        clearOps();
        addOp(16'hFFFF, 0); addOp(16'h0001, 2); addOp(16'h8000, 0);
        applyStimulus(3, 24'h018000, 7, 0);

        $display("[TB] len=0");
        clearOps();
        applyStimulus(0, 24'd0, 2, 0);

        $display("[TB] result backpressure");
        clearOps();
        addOp(16'h1234, 0); addOp(16'h0F0F, 0);
        applyStimulus(2, 24'h002143, 4, 5);

        $display("[TB] start right after backpressured job");
        clearOps();
        addOp(16'h0005, 0);
        applyStimulus(1, 24'd5, 3, 0);

        repeat (2) step();
        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
